// File: rtl/vdot_feed_if.sv
// Bundles the host-side load/control/result signals and the serial dot-unit link of vdot_feed.
// master = the sequencer itself; slave = the host plus dot-unit environment driving it.
interface vdot_feed_if #(
  parameter int N = 16,
  parameter int W = 16
);
  localparam int IW = $clog2(N);

  logic          wr_en;
  logic          wr_sel;
  logic [IW-1:0] wr_idx;
  logic [W-1:0]  wr_data;
  logic          go;
  logic          busy;
  logic [W-1:0]  a_elem;
  logic [W-1:0]  b_elem;
  logic          dot_start;
  logic [W-1:0]  dot_out;
  logic          dot_v;
  logic          dot_done;
  logic          res_valid;
  logic [W-1:0]  result;
  logic          ovf;
  logic          err;
  logic          res_ack;

  modport master (
    input  wr_en, wr_sel, wr_idx, wr_data, go, dot_out, dot_v, dot_done, res_ack,
    output busy, a_elem, b_elem, dot_start, res_valid, result, ovf, err
  );

  modport slave (
    output wr_en, wr_sel, wr_idx, wr_data, go, dot_out, dot_v, dot_done, res_ack,
    input  busy, a_elem, b_elem, dot_start, res_valid, result, ovf, err
  );
endinterface

// File: rtl/vdot_feed.sv
// Sequencer owning two N-element operand buffers: streams A[i]/B[i] pairs to a serial dot unit,
// waits (bounded) for completion, and holds the captured result until the host acknowledges it.
module vdot_feed #(
  parameter int N       = 16,
  parameter int W       = 16,
  parameter int TIMEOUT = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  vdot_feed_if.master  bus
);
  localparam int IW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  result_q, result_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;

  logic [W-1:0]  mem_a [N];
  logic [W-1:0]  mem_b [N];

  logic          wr_fire;
  logic [IW-1:0] idx_nxt;
  logic [CW-1:0] cnt_inc;
  logic [W-1:0]  first_a, first_b;

  assign wr_fire = bus.wr_en && (state_q == S_IDLE);
  assign idx_nxt = idx_q + IW'(1);
  assign cnt_inc = cnt_q + CW'(1);

  // A write issued together with go must already be seen by element 0.
  assign first_a = (wr_fire && !bus.wr_sel && (bus.wr_idx == '0)) ? bus.wr_data : mem_a[0];
  assign first_b = (wr_fire &&  bus.wr_sel && (bus.wr_idx == '0)) ? bus.wr_data : mem_b[0];

  // Operand storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (bus.wr_sel) mem_b[bus.wr_idx] <= bus.wr_data;
      else            mem_a[bus.wr_idx] <= bus.wr_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          state_d = S_STREAM;
          idx_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          err_d   = 1'b0;
          a_d     = first_a;
          b_d     = first_b;
        end
      end
      S_STREAM: begin
        ovf_d = ovf_q | bus.dot_v;
        if (idx_q == IW'(N - 1)) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          idx_d = idx_nxt;
          a_d   = mem_a[idx_nxt];
          b_d   = mem_b[idx_nxt];
        end
      end
      S_WAIT: begin
        ovf_d = ovf_q | bus.dot_v;
        cnt_d = cnt_inc;
        if (bus.dot_done) begin
          result_d = bus.dot_out;
          state_d  = S_HOLD;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          result_d = bus.dot_out;
          err_d    = 1'b1;
          state_d  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.res_ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  // Decoded straight from the state flop so reset drops dot_start without waiting for a clock.
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.dot_start = (state_q == S_STREAM) || (state_q == S_WAIT);
  assign bus.res_valid = (state_q == S_HOLD);
  assign bus.a_elem    = a_q;
  assign bus.b_elem    = b_q;
  assign bus.result    = result_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_vdot_feed.sv
// Self-checking bench for vdot_feed: per-operation expected traces built from the block's
// cycle rules, compared every cycle, plus literal checks on a few directed operations.
module tb_vdot_feed;
  localparam int N  = 16;
  localparam int W  = 16;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vdot_feed_if #(.N(N), .W(W)) bus ();
  vdot_feed #(.N(N), .W(W), .TIMEOUT(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct packed {
    logic         busy;
    logic         ds;
    logic         rv;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         ovf;
    logic         err;
  } obs_t;

  int tests = 0;
  int fails = 0;
  int ds_total = 0;

  obs_t act;
  obs_t exp_o;
  logic exp_en = 1'b0;

  logic [W-1:0] ma [N];
  logic [W-1:0] mb [N];
  logic [W-1:0] last_a = '0, last_b = '0, prev_res = '0;
  logic         prev_ovf = 1'b0, prev_err = 1'b0;

  assign act = {bus.busy, bus.dot_start, bus.res_valid, bus.a_elem, bus.b_elem,
                bus.result, bus.ovf, bus.err};

  always @(negedge clk) begin
    if (exp_en) begin
      tests++;
      if (act !== exp_o) begin
        fails++;
        $display("FAIL cycle_trace t=%0t got busy=%b ds=%b rv=%b a=%h b=%h res=%h ovf=%b err=%b want busy=%b ds=%b rv=%b a=%h b=%h res=%h ovf=%b err=%b",
                 $time, act.busy, act.ds, act.rv, act.a, act.b, act.res, act.ovf, act.err,
                 exp_o.busy, exp_o.ds, exp_o.rv, exp_o.a, exp_o.b, exp_o.res, exp_o.ovf, exp_o.err);
      end
    end
    ds_total += int'(bus.dot_start);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  function automatic obs_t idle_exp();
    return {1'b0, 1'b0, 1'b0, last_a, last_b, prev_res, prev_ovf, prev_err};
  endfunction

  task automatic junk_inputs();
    bus.dot_out  = W'($urandom);
    bus.dot_v    = 1'($urandom);
    bus.dot_done = 1'($urandom);
    bus.res_ack  = 1'($urandom);
  endtask

  task automatic idle_write(input logic sel, input int idx, input logic [W-1:0] d);
    junk_inputs();
    bus.go = 1'b0;
    bus.wr_en = 1'b1; bus.wr_sel = sel; bus.wr_idx = 4'(idx); bus.wr_data = d;
    if (sel) mb[idx] = d; else ma[idx] = d;
    exp_o = idle_exp();
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic idle_random(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) idle_write(1'($urandom), $urandom_range(0, N-1), W'($urandom));
      else begin
        junk_inputs();
        bus.go = 1'b0; bus.wr_en = 1'b0;
        exp_o = idle_exp();
        tick();
      end
    end
  endtask

  // dd: WAIT cycle (0-based) on which dot_done rises, <0 for never; vcyc: op cycle with a dot_v pulse.
  task automatic run_op(input int dd, input int vcyc, input int hc, input logic [W-1:0] capv,
                        input bit wr0, input logic [W-1:0] wr0_val);
    int   wc, cap;
    logic acc, errf, done_ok;
    done_ok = (dd >= 0) && (dd < TO);
    wc   = done_ok ? dd + 1 : TO;
    cap  = N + wc - 1;
    errf = !done_ok;
    acc  = 1'b0;
    junk_inputs();
    bus.go = 1'b1;
    bus.wr_en = wr0; bus.wr_sel = 1'b0; bus.wr_idx = '0; bus.wr_data = wr0_val;
    if (wr0) ma[0] = wr0_val;
    exp_o = idle_exp();
    tick();
    for (int c = 0; c <= cap + hc + 1; c++) begin
      bus.go      = (c < cap + hc) ? 1'($urandom) : 1'b0;
      bus.wr_en   = (c < cap + hc) ? 1'($urandom) : 1'b0;
      bus.wr_sel  = 1'($urandom);
      bus.wr_idx  = 4'($urandom);
      bus.wr_data = W'($urandom);
      bus.dot_out = (c == cap) ? capv : W'($urandom);
      bus.dot_v   = (c <= cap) ? (c == vcyc) : 1'($urandom);
      if (c < N)        bus.dot_done = 1'($urandom);
      else if (c < cap) bus.dot_done = 1'b0;
      else if (c == cap) bus.dot_done = done_ok;
      else              bus.dot_done = 1'($urandom);
      if (c <= cap)            bus.res_ack = 1'($urandom);
      else if (c < cap + hc)   bus.res_ack = 1'b0;
      else                     bus.res_ack = 1'b1;
      if (c < N)         exp_o = {1'b1, 1'b1, 1'b0, ma[c], mb[c], prev_res, acc, 1'b0};
      else if (c <= cap) exp_o = {1'b1, 1'b1, 1'b0, ma[N-1], mb[N-1], prev_res, acc, 1'b0};
      else if (c <= cap + hc) exp_o = {1'b1, 1'b0, 1'b1, ma[N-1], mb[N-1], capv, acc, errf};
      else               exp_o = {1'b0, 1'b0, 1'b0, ma[N-1], mb[N-1], capv, acc, errf};
      if (c <= cap) acc = acc | bus.dot_v;
      tick();
    end
    bus.res_ack = 1'b0;
    last_a = ma[N-1]; last_b = mb[N-1];
    prev_res = capv; prev_ovf = acc; prev_err = errf;
  endtask

  task automatic run_abort(input int at);
    junk_inputs();
    bus.go = 1'b1; bus.wr_en = 1'b0;
    exp_o = idle_exp();
    tick();
    bus.go = 1'b0; bus.dot_v = 1'b0; bus.dot_done = 1'b0;
    for (int c = 0; c < at; c++) begin
      exp_o = {1'b1, 1'b1, 1'b0, ma[c], mb[c], prev_res, 1'b0, 1'b0};
      tick();
    end
    exp_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_cleared", 64'(act), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    last_a = '0; last_b = '0; prev_res = '0; prev_ovf = 1'b0; prev_err = 1'b0;
    exp_o = idle_exp();
    exp_en = 1'b1;
    tick();
  endtask

  initial begin
    int ds0;
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_idx = '0; bus.wr_data = '0;
    bus.go = 1'b0; bus.dot_out = '0; bus.dot_v = 1'b0; bus.dot_done = 1'b0; bus.res_ack = 1'b0;
    #1;
    chk("reset_state", 64'(act), 64'd0);
    tick();
    rst_n = 1'b1;
    exp_o = idle_exp();
    exp_en = 1'b1;
    tick();

    // All-ones vectors, done two cycles after the last pair.
    for (int i = 0; i < N; i++) begin
      idle_write(1'b0, i, 16'h3c00);
      idle_write(1'b1, i, 16'h3c00);
    end
    ds0 = ds_total;
    run_op(1, -1, 3, 16'h4c00, 1'b0, '0);
    chk("ones_result", 64'(bus.result), 64'h4c00);
    chk("ones_ovf_err", 64'({bus.ovf, bus.err}), 64'd0);
    chk("ones_dot_start_cycles", 64'(ds_total - ds0), 64'd18);

    // 2.0 x 0.5 vectors, acknowledge delayed by five HOLD cycles.
    for (int i = 0; i < N; i++) begin
      idle_write(1'b0, i, 16'h4000);
      idle_write(1'b1, i, 16'h3800);
    end
    run_op(1, -1, 6, 16'h4c00, 1'b0, '0);
    chk("half_result", 64'(bus.result), 64'h4c00);
    chk("half_last_pair", 64'({bus.a_elem, bus.b_elem}), 64'h4000_3800);

    // No completion: WAIT must last exactly TIMEOUT cycles.
    ds0 = ds_total;
    run_op(-1, -1, 2, 16'h1234, 1'b0, '0);
    chk("timeout_err", 64'(bus.err), 64'd1);
    chk("timeout_dot_start_cycles", 64'(ds_total - ds0), 64'd24);

    // Overflow pulse at element 5 is sticky; next go clears it (with a write to A[0]).
    run_op(2, 5, 2, 16'h5000, 1'b0, '0);
    chk("ovf_sticky", 64'(bus.ovf), 64'd1);
    run_op(0, -1, 1, 16'h0001, 1'b1, 16'h0000);
    chk("ovf_cleared_by_go", 64'({bus.ovf, bus.err}), 64'd0);

    // Completion on the very cycle the timeout would fire.
    run_op(TO - 1, -1, 1, 16'h7bff, 1'b0, '0);
    chk("coincide_no_err", 64'(bus.err), 64'd0);

    idle_random(3);
    run_abort(7);
    run_op(0, -1, 1, 16'h2222, 1'b0, '0);
    chk("after_abort_result", 64'(bus.result), 64'h2222);

    for (int k = 0; k < 20; k++) begin
      int dd, vc;
      idle_random($urandom_range(0, 6));
      dd = int'($urandom_range(0, TO + 2)) - 1;
      vc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, N + TO)) : -1;
      run_op(dd, vc, $urandom_range(1, 4), W'($urandom), 1'($urandom), W'($urandom));
    end
    idle_random(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/vdot_feed.md
Name: vdot_feed

Overview:
- Single-clock sequencer that owns two N-element half-precision operand buffers and acts as the driving end of the serial dot-product interface.
- Host loads the buffers, then pulses go. The block streams element pairs (one per cycle) with dot_start held high, waits for dot_done, captures the scalar result and overflow, and holds them until the host acknowledges.
- Sits between the vector register file / host and the serial dot-product unit.

Parameters:
N, 16, elements per vector (power of two, ≥2)
W, 16, element/result width (IEEE half)
TIMEOUT, 8, max cycles to wait for dot_done after last element

Ports:
Clk  in  1  system clock, all state on rising edge
Rst_n  in  1  asynchronous active-low reset
wr_en  in  1  buffer write strobe
wr_sel  in  1  0=buffer A, 1=buffer B
wr_idx  in  log2(N)  element index
wr_data  in  W  element value
go  in  1  start request (level sampled)
busy  out  1  high whenever state != IDLE
a_elem  out  W  element A[idx] to dot unit
b_elem  out  W  element B[idx] to dot unit
dot_start  out  1  enable/hold for dot unit; low clears its accumulator
dot_out  in  W  dot unit accumulated result
dot_v  in  1  dot unit overflow
dot_done  in  1  dot unit completion
res_valid  out  1  result held
result  out  W  captured dot_out
ovf  out  1  sticky OR of dot_v over the operation
err  out  1  timeout flag, valid with res_valid
res_ack  in  1  host consumes result

Behaviour:
- Reset (async, Rst_n=0): state=IDLE, idx=0, dot_start=0, a_elem=b_elem=0, res_valid=0, result=0, ovf=0, err=0, busy=0, timeout counter=0. Buffer contents are not reset.
- States: IDLE, STREAM, WAIT, HOLD.
- IDLE:
  - wr_en writes wr_data into buffer[wr_sel][wr_idx] on the edge.
  - go=1 → STREAM, idx=0, ovf=0, err=0. If wr_en and go are both high, the write completes first and is visible to streaming.
- Writes are ignored in all states other than IDLE. go is ignored outside IDLE.
- STREAM:
  - a_elem/b_elem are registered from A[idx]/B[idx]; dot_start=1.
  - Element 0 appears on the cycle after go is sampled; one new pair per cycle; idx increments by 1.
  - After the pair with idx=N-1 is presented, go to WAIT. No wrap: idx saturates at N-1 and a_elem/b_elem hold the last pair.
  - ovf |= dot_v every cycle in STREAM and WAIT.
- WAIT:
  - dot_start stays 1; the counter increments each cycle.
  - dot_done=1 → capture result=dot_out, ovf |= dot_v, then HOLD.
  - Counter reaches TIMEOUT without dot_done → result=dot_out, err=1, then HOLD.
  - dot_done takes priority when it coincides with timeout (err=0).
  - dot_done asserted before WAIT (during STREAM) is ignored.
- HOLD:
  - res_valid=1, dot_start=0, busy=1. result, ovf and err are stable.
  - res_ack=1 → IDLE next cycle, res_valid=0. result, ovf and err keep their values until the next go.
  - res_ack outside HOLD has no effect.
- Latency, from go sampled to res_valid: N + (cycles in WAIT until dot_done) + 1.
- Reset mid-operation: immediate abort. dot_start drops asynchronously; no result is produced.
- The block performs no arithmetic on data; all values pass through bit-exact.

Test Plan:
- Load A[i]=B[i]=16'h3c00 for all 16 elements, go; model returns dot_done 2 cycles after the last pair → 16 consecutive pairs 3c00/3c00 with dot_start=1; result=16'h4c00, ovf=0, err=0, res_valid until res_ack.
- A[i]=16'h4000, B[i]=16'h3800, go → every pair is 4000/3800; result=16'h4c00. With res_ack held low for 5 cycles, res_valid and result stay stable, then clear on ack.
- Model never asserts dot_done → WAIT lasts exactly TIMEOUT=8 cycles; err=1, res_valid=1, dot_start=0 in HOLD.
- Model pulses dot_v for 1 cycle at element 5, then gives a normal done → ovf=1 sticky in HOLD. The next go clears ovf to 0.
- go and wr_en (A[0]=16'h0000) in the same IDLE cycle → first pair shows a_elem=0000. wr_en during STREAM is ignored (buffer read back unchanged). go during HOLD is ignored.
- Rst_n low at element 7 → dot_start=0, busy=0, res_valid=0 immediately. After release, a new go streams from idx 0.
